// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and defaults for the UART/ALU command sequencer
package uart_pkg;

   // Sequencer state encodings
   localparam logic [2:0] S_IDLE_ENC    = 3'd0;
   localparam logic [2:0] S_WAIT_B_ENC  = 3'd1;
   localparam logic [2:0] S_WAIT_OP_ENC = 3'd2;
   localparam logic [2:0] S_EXEC_ENC    = 3'd3;
   localparam logic [2:0] S_SEND_ENC    = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = S_IDLE_ENC,
      WAIT_B  = S_WAIT_B_ENC,
      WAIT_OP = S_WAIT_OP_ENC,
      EXEC    = S_EXEC_ENC,
      SEND    = S_SEND_ENC
   } state_e;

   localparam int DBIT_DEF  = 8;
   localparam int NB_OP_DEF = 6;

   // One character (start + 8 data + stop) at the line rate bounds the gap between bytes
   localparam int CLK_HZ        = 50_000_000;
   localparam int BAUD          = 10_000;
   localparam int BITS_PER_CHAR = 10;
   localparam int TIMEOUT_DEF   = (CLK_HZ / BAUD) * BITS_PER_CHAR;

   // Counter width for a count range of 0..n-1, never below one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_timeout.sv
// rtl/frame_timeout.sv - inter-byte timeout counter with clear, enable and terminal count
module frame_timeout
   import uart_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int             CW     = cnt_width(TIMEOUT);
   localparam logic [CW-1:0]  TC_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear has priority over counting
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - collects A/B/opcode bytes, drives the ALU and returns its result over UART
module uart_alu_ctrl
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEF,
   parameter int NB_OP   = NB_OP_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rx_done_tick,
   input  logic [DBIT-1:0]  rx_data,
   input  logic             tx_done_tick,
   input  logic [DBIT-1:0]  alu_result,
   output logic [DBIT-1:0]  alu_a,
   output logic [DBIT-1:0]  alu_b,
   output logic [NB_OP-1:0] alu_op,
   output logic             tx_start,
   output logic [DBIT-1:0]  tx_data,
   output logic             busy,
   output logic             timeout_err,
   output logic             overrun
);

   state_e           state_q, state_d;
   logic [DBIT-1:0]  alu_a_q, alu_a_d;
   logic [DBIT-1:0]  alu_b_q, alu_b_d;
   logic [NB_OP-1:0] alu_op_q, alu_op_d;
   logic [DBIT-1:0]  tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             timeout_err_q, timeout_err_d;
   logic             overrun_q, overrun_d;

   logic waiting;
   logic tc;
   logic timeout_hit;

   // The timer only runs while a frame is partially received; a byte in the
   // terminal-count cycle wins over the timeout
   assign waiting     = (state_q == WAIT_B) || (state_q == WAIT_OP);
   assign timeout_hit = waiting && tc && !rx_done_tick;

   frame_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_frame_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (rx_done_tick || !waiting || timeout_hit),
      .en      (waiting),
      .tc      (tc)
   );

   // Next state, operand capture and one-cycle output pulses
   always_comb begin
      state_d       = state_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_op_d      = alu_op_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      timeout_err_d = 1'b0;
      overrun_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_done_tick) begin
               alu_a_d = rx_data;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (rx_done_tick) begin
               alu_b_d = rx_data;
               state_d = WAIT_OP;
            end else if (timeout_hit) begin
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end
         end
         WAIT_OP: begin
            if (rx_done_tick) begin
               alu_op_d = rx_data[NB_OP-1:0];
               state_d  = EXEC;
            end else if (timeout_hit) begin
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end
         end
         EXEC: begin
            // ALU inputs have been stable for a full cycle; latch its result
            tx_data_d  = alu_result;
            tx_start_d = 1'b1;
            overrun_d  = rx_done_tick;
            state_d    = SEND;
         end
         SEND: begin
            overrun_d = rx_done_tick;
            if (tx_done_tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand, result and pulse registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= '0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_op_q      <= alu_op_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         timeout_err_q <= timeout_err_d;
         overrun_q     <= overrun_d;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign timeout_err = timeout_err_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != IDLE);

endmodule
